// File: rtl/tcp_msg_poller_pkg.sv
// Shared definitions for the TCP message-pointer poller control.
// Contents:
//   enq_state_e        - enqueue-stage states (READY, WR_MEM, ENQ)
//   FLOWID_W_DEF       - default flow id width
//   MSG_LEN_W_DEF      - default requested-length width
// The poller control imports this package for the same widths.
package tcp_msg_poller_pkg;

    localparam int FLOWID_W_DEF  = 3;
    localparam int MSG_LEN_W_DEF = 32;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        WR_MEM = 2'd1,
        ENQ    = 2'd2
    } enq_state_e;

endpackage

// File: rtl/tcp_poller_active_bitvec.sv
// Per-flow "active" bitvector with a running popcount.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   set_val/set_flowid  - mark a flow active
//   clear_val/clear_flowid - release a flow (ignored if already clear)
//   rd_flowid/rd_active - combinational read; a same-cycle clear is bypassed
//                         so the reader sees the post-clear value
//   active_cnt          - number of set bits
// A set and a clear to the same flow in one cycle resolve to set.
module tcp_poller_active_bitvec #(
    parameter int FLOWID_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_val,
    input  logic [FLOWID_W-1:0] set_flowid,
    input  logic                clear_val,
    input  logic [FLOWID_W-1:0] clear_flowid,
    input  logic [FLOWID_W-1:0] rd_flowid,
    output logic                rd_active,
    output logic [FLOWID_W:0]   active_cnt
);

    localparam int NUM_FLOWS = 1 << FLOWID_W;

    logic [NUM_FLOWS-1:0] active_reg;
    logic [NUM_FLOWS-1:0] active_next;
    logic [FLOWID_W:0]    cnt_reg;
    logic [FLOWID_W:0]    cnt_next;
    logic                 set_inc;
    logic                 clr_dec;
    logic                 same_flow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOWS; gi++) begin : g_bit
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_val && (set_flowid == FLOWID_W'(gi));
            assign clr_hit = clear_val && (clear_flowid == FLOWID_W'(gi));
            // Set has priority over clear on the same flow.
            assign active_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : active_reg[gi]);
        end
    endgenerate

    assign same_flow = set_val && clear_val && (set_flowid == clear_flowid);
    // Count only real transitions: 0->1 on set, 1->0 on a clear that the set
    // does not override.
    assign set_inc   = set_val && !active_reg[set_flowid];
    assign clr_dec   = clear_val && active_reg[clear_flowid] && !same_flow;

    always_comb begin
        cnt_next = cnt_reg;
        if (set_inc && !clr_dec) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (clr_dec && !set_inc) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign rd_active  = active_reg[rd_flowid] &&
                        !(clear_val && (clear_flowid == rd_flowid));
    assign active_cnt = cnt_reg;

endmodule

// File: rtl/tcp_msg_ptr_poller_enq.sv
// Upstream stage of the TCP message-pointer poller control.
// Accepts (flowid, length) requests from the application, writes the length
// into the message-request memory at the flowid address, then pushes the
// flowid onto the message-request queue unless the flow is already active.
// Owns the per-flow active bitvector; the poller clears a flow once it has
// sent the notification.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   app_poller_msg_req_*            - application request (val/flowid/len)
//   poller_app_msg_req_rdy          - request accepted
//   enq_msg_req_mem_wr_req_*        - request-memory write (val/addr/data)
//   msg_req_mem_enq_wr_req_rdy      - memory write ready
//   enq_msg_req_q_wr_req_*          - request-queue push (val/data)
//   msg_req_q_enq_wr_req_rdy        - queue push ready
//   poll_active_bitvec_clear_req_*  - poller releases a flow
//   enq_active_flow_cnt             - number of active flows
// Build option TCP_POLLER_ENQ_STALL_ACTIVE_EN: when defined, a request to an
// active flow is held off (rdy low) until that flow is cleared, so WR_MEM
// always takes the push path.
module tcp_msg_ptr_poller_enq
    import tcp_msg_poller_pkg::*;
#(
    parameter int FLOWID_W  = FLOWID_W_DEF,
    parameter int MSG_LEN_W = MSG_LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 app_poller_msg_req_val,
    input  logic [FLOWID_W-1:0]  app_poller_msg_req_flowid,
    input  logic [MSG_LEN_W-1:0] app_poller_msg_req_len,
    output logic                 poller_app_msg_req_rdy,
    output logic                 enq_msg_req_mem_wr_req_val,
    output logic [FLOWID_W-1:0]  enq_msg_req_mem_wr_req_addr,
    output logic [MSG_LEN_W-1:0] enq_msg_req_mem_wr_req_data,
    input  logic                 msg_req_mem_enq_wr_req_rdy,
    output logic                 enq_msg_req_q_wr_req_val,
    output logic [FLOWID_W-1:0]  enq_msg_req_q_wr_req_data,
    input  logic                 msg_req_q_enq_wr_req_rdy,
    input  logic                 poll_active_bitvec_clear_req_val,
    input  logic [FLOWID_W-1:0]  poll_active_bitvec_clear_req_flowid,
    output logic [FLOWID_W:0]    enq_active_flow_cnt
);

    enq_state_e           state_reg;
    enq_state_e           state_next;
    logic [FLOWID_W-1:0]  flowid_reg;
    logic [MSG_LEN_W-1:0] len_reg;
    logic                 latch_en;
    logic                 app_rdy;
    logic                 set_val;
    logic [FLOWID_W-1:0]  rd_flowid;
    logic                 rd_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= READY;
            flowid_reg <= '0;
            len_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                flowid_reg <= app_poller_msg_req_flowid;
                len_reg    <= app_poller_msg_req_len;
            end
        end
    end

    always_comb begin
        state_next                 = state_reg;
        latch_en                   = 1'b0;
        app_rdy                    = 1'b0;
        set_val                    = 1'b0;
        enq_msg_req_mem_wr_req_val = 1'b0;
        enq_msg_req_q_wr_req_val   = 1'b0;
        rd_flowid                  = flowid_reg;
        case (state_reg)
            READY: begin
                // Look up the incoming flow so the stall option can gate rdy.
                rd_flowid = app_poller_msg_req_flowid;
`ifdef TCP_POLLER_ENQ_STALL_ACTIVE_EN
                app_rdy = !app_poller_msg_req_val || !rd_active;
`else
                app_rdy = 1'b1;
`endif
                if (app_poller_msg_req_val && app_rdy) begin
                    latch_en   = 1'b1;
                    state_next = WR_MEM;
                end
            end
            WR_MEM: begin
                enq_msg_req_mem_wr_req_val = 1'b1;
                if (msg_req_mem_enq_wr_req_rdy) begin
`ifdef TCP_POLLER_ENQ_STALL_ACTIVE_EN
                    set_val    = 1'b1;
                    state_next = ENQ;
`else
                    // A flow still awaiting notification is already queued:
                    // the length update is enough. rd_active already folds
                    // in a same-cycle clear, which turns the hit into a miss.
                    if (rd_active) begin
                        state_next = READY;
                    end else begin
                        set_val    = 1'b1;
                        state_next = ENQ;
                    end
`endif
                end
            end
            ENQ: begin
                enq_msg_req_q_wr_req_val = 1'b1;
                if (msg_req_q_enq_wr_req_rdy) begin
                    state_next = READY;
                end
            end
            default: state_next = READY;
        endcase
    end

    // rdy is held low while reset is asserted so nothing is handshaken then.
    assign poller_app_msg_req_rdy      = app_rdy && !rst;
    assign enq_msg_req_mem_wr_req_addr = flowid_reg;
    assign enq_msg_req_mem_wr_req_data = len_reg;
    assign enq_msg_req_q_wr_req_data   = flowid_reg;

    tcp_poller_active_bitvec #(
        .FLOWID_W (FLOWID_W)
    ) u_active_bitvec (
        .clk          (clk),
        .rst          (rst),
        .set_val      (set_val),
        .set_flowid   (flowid_reg),
        .clear_val    (poll_active_bitvec_clear_req_val),
        .clear_flowid (poll_active_bitvec_clear_req_flowid),
        .rd_flowid    (rd_flowid),
        .rd_active    (rd_active),
        .active_cnt   (enq_active_flow_cnt)
    );

endmodule

// File: tb/tb_tcp_msg_ptr_poller_enq.sv
// Self-checking bench for tcp_msg_ptr_poller_enq: directed scenarios followed
// by randomized traffic, all compared cycle by cycle against a
// transaction-level reference model (one outstanding request, per-flow
// active flags, count = number of active flags).
module tb_tcp_msg_ptr_poller_enq;

    localparam int FW = 3;
    localparam int LW = 32;
    localparam int NF = 1 << FW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_val = 1'b0;
    logic [FW-1:0] req_flowid = '0;
    logic [LW-1:0] req_len = '0;
    logic          app_rdy;
    logic          mem_val;
    logic [FW-1:0] mem_addr;
    logic [LW-1:0] mem_data;
    logic          mem_rdy = 1'b0;
    logic          q_val;
    logic [FW-1:0] q_data;
    logic          q_rdy = 1'b0;
    logic          clr_val = 1'b0;
    logic [FW-1:0] clr_flowid = '0;
    logic [FW:0]   active_cnt;

    always #5 clk = ~clk;

    tcp_msg_ptr_poller_enq #(.FLOWID_W(FW), .MSG_LEN_W(LW)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .app_poller_msg_req_val              (req_val),
        .app_poller_msg_req_flowid           (req_flowid),
        .app_poller_msg_req_len              (req_len),
        .poller_app_msg_req_rdy              (app_rdy),
        .enq_msg_req_mem_wr_req_val          (mem_val),
        .enq_msg_req_mem_wr_req_addr         (mem_addr),
        .enq_msg_req_mem_wr_req_data         (mem_data),
        .msg_req_mem_enq_wr_req_rdy          (mem_rdy),
        .enq_msg_req_q_wr_req_val            (q_val),
        .enq_msg_req_q_wr_req_data           (q_data),
        .msg_req_q_enq_wr_req_rdy            (q_rdy),
        .poll_active_bitvec_clear_req_val    (clr_val),
        .poll_active_bitvec_clear_req_flowid (clr_flowid),
        .enq_active_flow_cnt                 (active_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the outstanding request (if any), whether its memory
    // write has completed, and the set of active flows.
    bit          m_busy;
    bit          m_written;
    int          m_flow;
    logic [LW-1:0] m_len;
    bit          m_active [NF];
    int          m_pushes;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NF; i++) n += int'(m_active[i]);
        return n;
    endfunction

    function automatic bit m_seen_active(input int f, input bit cv, input int cf);
        return m_active[f] && !(cv && cf == f);
    endfunction

    task automatic model_reset();
        m_busy    = 0;
        m_written = 0;
        m_flow    = 0;
        m_len     = '0;
        for (int i = 0; i < NF; i++) m_active[i] = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input bit rv, input int rf, input logic [LW-1:0] rl,
                        input bit mr, input bit qr, input bit cv, input int cf);
        bit exp_rdy;
        bit hit;
        int set_f;
        @(negedge clk);
        req_val    = rv;
        req_flowid = FW'(rf);
        req_len    = rl;
        mem_rdy    = mr;
        q_rdy      = qr;
        clr_val    = cv;
        clr_flowid = FW'(cf);
        #1;
        exp_rdy = !m_busy;
`ifdef TCP_POLLER_ENQ_STALL_ACTIVE_EN
        exp_rdy = exp_rdy && (!rv || !m_seen_active(rf, cv, cf));
`endif
        check("app_rdy", 64'(app_rdy), 64'(exp_rdy));
        check("mem_val", 64'(mem_val), 64'(m_busy && !m_written));
        if (m_busy && !m_written) begin
            check("mem_addr", 64'(mem_addr), 64'(m_flow));
            check("mem_data", 64'(mem_data), 64'(m_len));
        end
        check("q_val", 64'(q_val), 64'(m_busy && m_written));
        if (m_busy && m_written) check("q_data", 64'(q_data), 64'(m_flow));
        check("cnt", 64'(active_cnt), 64'(m_count()));

        set_f = -1;
        if (m_busy && !m_written) begin
            if (mr) begin
`ifdef TCP_POLLER_ENQ_STALL_ACTIVE_EN
                hit = 0;
`else
                hit = m_seen_active(m_flow, cv, cf);
`endif
                if (hit) begin
                    m_busy = 0;
                end else begin
                    set_f     = m_flow;
                    m_written = 1;
                end
            end
        end else if (m_busy) begin
            if (qr) begin
                m_busy = 0;
                m_pushes++;
            end
        end else if (rv && exp_rdy) begin
            m_busy    = 1;
            m_written = 0;
            m_flow    = rf;
            m_len     = rl;
        end
        if (cv) m_active[cf] = 0;
        if (set_f >= 0) m_active[set_f] = 1;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        req_val = 1'b0;
        mem_rdy = 1'b0;
        q_rdy   = 1'b0;
        clr_val = 1'b0;
        #1;
        check("rst_app_rdy", 64'(app_rdy), 64'd0);
        check("rst_mem_val", 64'(mem_val), 64'd0);
        check("rst_q_val", 64'(q_val), 64'd0);
        check("rst_cnt", 64'(active_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        m_pushes = 0;
        model_reset();
        apply_reset();

        // Single request: flow 2, len 100 -> write, push, count 1.
        step(1, 2, 32'd100, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0);
        idle();
        check("single_cnt", 64'(active_cnt), 64'd1);

`ifndef TCP_POLLER_ENQ_STALL_ACTIVE_EN
        // Duplicate request on active flow 2: write only, no push.
        step(1, 2, 32'd40, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        idle();
        check("dup_no_push", 64'(q_val), 64'd0);
        check("dup_cnt", 64'(active_cnt), 64'd1);
`endif

        // Release flow 2, then request it again: pushed again.
        step(0, 0, '0, 0, 0, 1, 2);
        idle();
        check("release_cnt", 64'(active_cnt), 64'd0);
        step(1, 2, 32'd55, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0);

        // Make flow 5 active.
        step(1, 5, 32'd9, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0);
        idle();
        check("two_active_cnt", 64'(active_cnt), 64'd2);

`ifndef TCP_POLLER_ENQ_STALL_ACTIVE_EN
        // Clear race: clear 5 during the WR_MEM handshake of flow 5 -> push.
        step(1, 5, 32'd7, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 1, 5);
        idle();
        check("race_push_val", 64'(q_val), 64'd1);
        check("race_push_data", 64'(q_data), 64'd5);
        step(0, 0, '0, 0, 1, 0, 0);
        idle();
        check("race_cnt", 64'(active_cnt), 64'd2);
`else
        // Stall: request active flow 5 is held until 5 is cleared.
        for (int i = 0; i < 4; i++) step(1, 5, 32'd7, 0, 0, 0, 0);
        check("stall_rdy", 64'(app_rdy), 64'd0);
        step(1, 5, 32'd7, 0, 0, 1, 5);
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0);
        idle();
        check("stall_cnt", 64'(active_cnt), 64'd2);
`endif

        // Backpressure: push of flow 3 held off 10 cycles.
        step(1, 3, 32'd300, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 4, 32'd1, 0, 0, 0, 0);
        check("bp_q_data", 64'(q_data), 64'd3);
        step(0, 0, '0, 0, 1, 0, 0);
        idle();
        check("bp_cnt", 64'(active_cnt), 64'd3);

        // Reset in ENQ: nothing pushed, bitvector empty.
        step(1, 6, 32'd66, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        apply_reset();
        idle();
        check("post_rst_q_val", 64'(q_val), 64'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                apply_reset();
            end else begin
                step($urandom_range(0, 1) == 1, int'($urandom_range(0, NF - 1)), $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) == 0, int'($urandom_range(0, NF - 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
